// File: rtl/testpattern_mc_if.sv
// Video output bus of the test-pattern generator: data enable, syncs, start-of-frame
// and one DATA_W-bit sample per colour channel.
interface testpattern_mc_if #(
  parameter int DATA_W = 8
);
  logic              O_de;
  logic              O_hs;
  logic              O_vs;
  logic              O_sof;
  logic [DATA_W-1:0] O_data_r;
  logic [DATA_W-1:0] O_data_g;
  logic [DATA_W-1:0] O_data_b;

  modport master (output O_de, O_hs, O_vs, O_sof, O_data_r, O_data_g, O_data_b);
  modport slave  (input  O_de, O_hs, O_vs, O_sof, O_data_r, O_data_g, O_data_b);
endinterface

// File: rtl/testpattern_mc.sv
// Programmable raster timing plus eight test patterns, configuration shadowed per frame.
// Optional PRBS-23 pattern (mode 6) is compiled in when TPG_PRBS_EN is defined.
module testpattern_mc #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int GRID_LOG2 = 5,
  parameter int CHK_LOG2  = 4,
  parameter int MOVE_W    = 64
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst,
  input  logic [2:0]        I_mode,
  input  logic [DATA_W-1:0] I_single_r,
  input  logic [DATA_W-1:0] I_single_g,
  input  logic [DATA_W-1:0] I_single_b,
  input  logic [CNT_W-1:0]  I_h_total,
  input  logic [CNT_W-1:0]  I_h_sync,
  input  logic [CNT_W-1:0]  I_h_bporch,
  input  logic [CNT_W-1:0]  I_h_res,
  input  logic [CNT_W-1:0]  I_v_total,
  input  logic [CNT_W-1:0]  I_v_sync,
  input  logic [CNT_W-1:0]  I_v_bporch,
  input  logic [CNT_W-1:0]  I_v_res,
  input  logic              I_hs_pol,
  input  logic              I_vs_pol,
  input  logic [7:0]        I_step,
  testpattern_mc_if.master  vid
);
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   pos_t;
  typedef logic [CNT_W+1:0] wide_t;
  localparam logic [DATA_W-1:0] MAX = '1;

  logic [2:0]        sh_mode;
  logic [DATA_W-1:0] sh_single_r, sh_single_g, sh_single_b;
  cnt_t              sh_h_total, sh_h_sync, sh_h_bporch, sh_h_res;
  cnt_t              sh_v_total, sh_v_sync, sh_v_bporch, sh_v_res;
  logic              sh_hs_pol, sh_vs_pol;
  logic [7:0]        sh_step;

  cnt_t              h_cnt, v_cnt, h_pos, v_pos, bar_cnt, x, y, bar_w;
  logic [2:0]        bar_idx, bar_mask;
  logic              h_last, v_last, frame_end, h_act, v_act, de_raw, h_bar, v_bar;
  wide_t             h_start, v_start;
  pos_t              h_pos_sum, v_pos_sum;
  cnt_t              h_pos_nxt, v_pos_nxt;
  logic [DATA_W-1:0] pix_r, pix_g, pix_b;
  logic              s1_de, s1_hs, s1_vs, s1_sof;
  logic [DATA_W-1:0] s1_r, s1_g, s1_b;

  // Wrap compares are >= so a counter beyond a freshly shrunk total recovers in one cycle.
  assign h_last    = (wide_t'(h_cnt) + wide_t'(1)) >= wide_t'(sh_h_total);
  assign v_last    = (wide_t'(v_cnt) + wide_t'(1)) >= wide_t'(sh_v_total);
  assign frame_end = h_last && v_last;

  assign h_start = wide_t'(sh_h_sync) + wide_t'(sh_h_bporch);
  assign v_start = wide_t'(sh_v_sync) + wide_t'(sh_v_bporch);
  assign h_act   = (wide_t'(h_cnt) >= h_start) && (wide_t'(h_cnt) < h_start + wide_t'(sh_h_res));
  assign v_act   = (wide_t'(v_cnt) >= v_start) && (wide_t'(v_cnt) < v_start + wide_t'(sh_v_res));
  assign de_raw  = h_act && v_act;
  assign x       = cnt_t'(wide_t'(h_cnt) - h_start);
  assign y       = cnt_t'(wide_t'(v_cnt) - v_start);
  assign bar_w   = sh_h_res >> 3;

  assign h_bar = (wide_t'(x) >= wide_t'(h_pos)) && (wide_t'(x) < wide_t'(h_pos) + wide_t'(MOVE_W));
  assign v_bar = (wide_t'(y) >= wide_t'(v_pos)) && (wide_t'(y) < wide_t'(v_pos) + wide_t'(MOVE_W));

  assign h_pos_sum = pos_t'(h_pos) + pos_t'(sh_step);
  assign v_pos_sum = pos_t'(v_pos) + pos_t'(sh_step);
  assign h_pos_nxt = (h_pos_sum >= pos_t'(sh_h_res)) ? cnt_t'(h_pos_sum - pos_t'(sh_h_res)) : cnt_t'(h_pos_sum);
  assign v_pos_nxt = (v_pos_sum >= pos_t'(sh_v_res)) ? cnt_t'(v_pos_sum - pos_t'(sh_v_res)) : cnt_t'(v_pos_sum);

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst || frame_end) begin
      sh_mode     <= I_mode;
      sh_single_r <= I_single_r;
      sh_single_g <= I_single_g;
      sh_single_b <= I_single_b;
      sh_h_total  <= I_h_total;
      sh_h_sync   <= I_h_sync;
      sh_h_bporch <= I_h_bporch;
      sh_h_res    <= I_h_res;
      sh_v_total  <= I_v_total;
      sh_v_sync   <= I_v_sync;
      sh_v_bporch <= I_v_bporch;
      sh_v_res    <= I_v_res;
      sh_hs_pol   <= I_hs_pol;
      sh_vs_pol   <= I_vs_pol;
      sh_step     <= I_step;
    end
  end

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      h_pos <= '0;
      v_pos <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + cnt_t'(1);
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + cnt_t'(1);
      if (frame_end) begin
        h_pos <= h_pos_nxt;
        v_pos <= v_pos_nxt;
      end
    end
  end

  // Divider-free bar index: count bar_w pixels per bar; the last bar soaks up the remainder.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst || !de_raw || h_last) begin
      bar_idx <= '0;
      bar_cnt <= '0;
    end else if ((bar_cnt == bar_w - cnt_t'(1)) && (bar_idx != 3'd7)) begin
      bar_idx <= bar_idx + 3'd1;
      bar_cnt <= '0;
    end else begin
      bar_cnt <= bar_cnt + cnt_t'(1);
    end
  end

`ifdef TPG_PRBS_EN
  logic [22:0] lfsr;

  function automatic logic [DATA_W-1:0] prbs_slice(input logic [22:0] s, input int base);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W; i++)
      v[i] = s[(base + i) % 23];
    return v;
  endfunction

  // Reseeding on every shadow load makes each frame's PRBS content identical.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst || frame_end)
      lfsr <= '1;
    else if (de_raw)
      lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
  end
`endif

  always_comb begin
    pix_r    = '0;
    pix_g    = '0;
    pix_b    = '0;
    bar_mask = 3'b000;
    case (bar_idx)
      3'd0: bar_mask = 3'b111;
      3'd1: bar_mask = 3'b110;
      3'd2: bar_mask = 3'b011;
      3'd3: bar_mask = 3'b010;
      3'd4: bar_mask = 3'b101;
      3'd5: bar_mask = 3'b100;
      3'd6: bar_mask = 3'b001;
      default: bar_mask = 3'b000;
    endcase
    if (de_raw) begin
      case (sh_mode)
        3'd0: begin
          if (bar_w == '0) begin
            pix_r = MAX; pix_g = MAX; pix_b = MAX;
          end else begin
            pix_r = {DATA_W{bar_mask[2]}};
            pix_g = {DATA_W{bar_mask[1]}};
            pix_b = {DATA_W{bar_mask[0]}};
          end
        end
        3'd1: begin
          if ((x[GRID_LOG2-1:0] == '0) || (y[GRID_LOG2-1:0] == '0) ||
              (x == sh_h_res - cnt_t'(1)) || (y == sh_v_res - cnt_t'(1)))
            pix_r = MAX;
        end
        3'd2: begin
          pix_r = x[DATA_W-1:0]; pix_g = x[DATA_W-1:0]; pix_b = x[DATA_W-1:0];
        end
        3'd3: begin
          pix_r = {DATA_W{h_bar}}; pix_g = {DATA_W{h_bar}}; pix_b = {DATA_W{h_bar}};
        end
        3'd4: begin
          pix_r = {DATA_W{v_bar}}; pix_g = {DATA_W{v_bar}}; pix_b = {DATA_W{v_bar}};
        end
        3'd5: begin
          pix_r = {DATA_W{x[CHK_LOG2] ^ y[CHK_LOG2]}};
          pix_g = pix_r;
          pix_b = pix_r;
        end
        3'd6: begin
`ifdef TPG_PRBS_EN
          pix_r = prbs_slice(lfsr, 0);
          pix_g = prbs_slice(lfsr, DATA_W);
          pix_b = prbs_slice(lfsr, 2 * DATA_W);
`endif
        end
        default: begin
          pix_r = sh_single_r; pix_g = sh_single_g; pix_b = sh_single_b;
        end
      endcase
    end
  end

  // Two register stages keep every output exactly two cycles behind the counters.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      s1_de  <= 1'b0;
      s1_hs  <= ~I_hs_pol;
      s1_vs  <= ~I_vs_pol;
      s1_sof <= 1'b0;
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
      vid.O_de     <= 1'b0;
      vid.O_hs     <= ~I_hs_pol;
      vid.O_vs     <= ~I_vs_pol;
      vid.O_sof    <= 1'b0;
      vid.O_data_r <= '0;
      vid.O_data_g <= '0;
      vid.O_data_b <= '0;
    end else begin
      s1_de  <= de_raw;
      s1_hs  <= ~((h_cnt < sh_h_sync) ^ sh_hs_pol);
      s1_vs  <= ~((v_cnt < sh_v_sync) ^ sh_vs_pol);
      s1_sof <= de_raw && (x == '0) && (y == '0);
      s1_r   <= pix_r;
      s1_g   <= pix_g;
      s1_b   <= pix_b;
      vid.O_de     <= s1_de;
      vid.O_hs     <= s1_hs;
      vid.O_vs     <= s1_vs;
      vid.O_sof    <= s1_sof;
      vid.O_data_r <= s1_r;
      vid.O_data_g <= s1_g;
      vid.O_data_b <= s1_b;
    end
  end
endmodule
